u8dbg_target: RTL and testbench

- Target-side responder for the two-wire nX-U8 debug port (sclk, sdata) driven by the u8dbg master.
- Oversamples the bus on the fabric clock and decodes start, direction, 7-bit register address and 16-bit data.
- Issues single-cycle register write/read strobes to a local debug register file; on reads, drives the 16-bit reply onto sdata.
- Serves as the bench/emulation partner for the master and as the target port of a soft-core debug unit.

---
 rtl/u8dbg_target.sv | 185 ++++++++++++++++++
 tb/tb_u8dbg_target.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/u8dbg_target.sv
// u8dbg_target: oversampling target for the two-wire nX-U8 debug port.
// Optional mid-frame sclk timeout: define U8DBG_TGT_TIMEOUT_EN.
module u8dbg_target #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        sdata_in,
  output logic        sdata_out,
  output logic        sdata_oe,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RDREQ,
    S_RDLAT, S_TURN, S_RDATA
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_h, sda_h;
  logic rise, fall, start, stop, timeout;

  logic [3:0]  cnt, cnt_n;
  logic [15:0] sh, sh_n;
  logic [15:0] wdata_n;
  logic [6:0]  addr_n;
  logic sdo_n, oe_n, we_n, re_n, err_n;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign rise  = scl_s & ~scl_h;
  assign fall  = ~scl_s & scl_h;
  assign start = scl_s & sda_h & ~sda_s;
  assign stop  = scl_s & ~sda_h & sda_s;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sdata_in};
      scl_h    <= scl_s;
      sda_h    <= sda_s;
    end
  end

`ifdef U8DBG_TGT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || !busy || rise || fall)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = busy && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    sdo_n   = sdata_out;
    oe_n    = sdata_oe;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;
    we_n    = 1'b0;
    re_n    = 1'b0;
    err_n   = 1'b0;
    // bus conditions win over bit sampling in the same cycle
    if (start) begin
      state_n = S_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      sdo_n   = 1'b1;
      err_n   = busy;
    end else if ((stop && busy) || timeout) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      sdo_n   = 1'b1;
      err_n   = 1'b1;
    end else begin
      unique case (state)
        S_ADDR: if (rise) begin
          sh_n  = {sh[14:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            addr_n  = {sh[5:0], sda_s};
            cnt_n   = '0;
            re_n    = sh[6];
            state_n = sh[6] ? S_RDREQ : S_WDATA;
          end
        end
        S_WDATA: if (rise) begin
          sh_n  = {sh[14:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            wdata_n = {sh[14:0], sda_s};
            we_n    = 1'b1;
            cnt_n   = '0;
            state_n = S_IDLE;
          end
        end
        S_RDREQ: state_n = S_RDLAT;
        S_RDLAT: begin
          sh_n    = reg_rdata;
          cnt_n   = '0;
          state_n = S_TURN;
        end
        // the fall ending the address byte is ignored until a turn rise
        S_TURN: begin
          if (rise) begin
            cnt_n = 4'd1;
          end else if (fall && cnt == 4'd1) begin
            oe_n    = 1'b1;
            sdo_n   = sh[15];
            sh_n    = {sh[14:0], 1'b0};
            cnt_n   = '0;
            state_n = S_RDATA;
          end
        end
        S_RDATA: if (fall) begin
          if (cnt == 4'd15) begin
            oe_n    = 1'b0;
            sdo_n   = 1'b1;
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            sdo_n = sh[15];
            sh_n  = {sh[14:0], 1'b0};
            cnt_n = cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      sdata_out <= 1'b1;
      sdata_oe  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      sdata_out <= sdo_n;
      sdata_oe  <= oe_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      reg_re    <= re_n;
      frame_err <= err_n;
    end
  end

endmodule

// File: tb/tb_u8dbg_target.sv
// tb_u8dbg_target: bus-level master, register file and event scoreboard.
// Strobes/errors are matched in order against a queue filled by the stimulus.
module tb_u8dbg_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_scl, m_sda;
  logic        sda_bus;
  logic        sdata_out, sdata_oe;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy, frame_err;

  int total = 0;
  int bad   = 0;
  int H     = 8;

  typedef struct {
    int          kind;
    logic [6:0]  a;
    logic [15:0] d;
  } ev_t;

  ev_t evq[$];
  logic [15:0] env_mem[128];
  logic [15:0] ref_mem[128];

  u8dbg_target #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .sclk(m_scl), .sdata_in(sda_bus),
    .sdata_out(sdata_out), .sdata_oe(sdata_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  assign sda_bus = sdata_oe ? sdata_out : m_sda;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_we) env_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= env_mem[reg_addr];
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half();
    cyc(H);
  endtask

  task automatic expect_ev(int k, logic [6:0] a, logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    evq.push_back(e);
  endtask

  task automatic start_cond();
    if (!m_scl) begin
      m_sda = 1'b1; half();
      m_scl = 1'b1; half();
    end
    m_sda = 1'b0; half();
    m_scl = 1'b0; cyc(2);
  endtask

  task automatic send_bit(logic b);
    m_sda = b;    half();
    m_scl = 1'b1; half();
    m_scl = 1'b0; cyc(2);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; half();
    m_scl = 1'b1; half();
    m_sda = 1'b1; half();
  endtask

  task automatic do_write(logic [6:0] a, logic [15:0] d, int abort_bits);
    logic [7:0] b;
    int n;
    b = {1'b0, a};
    start_cond();
    if (abort_bits < 0) begin
      expect_ev(0, a, d);
      ref_mem[a] = d;
      n = 16;
    end else begin
      expect_ev(2, 7'd0, 16'd0);
      n = abort_bits;
    end
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    for (int i = 0; i < n; i++) send_bit(d[15-i]);
    stop_cond();
    if (abort_bits >= 0) begin
      cyc(4);
      chk("busy_after_abort", 32'(busy), 0);
    end
  endtask

  task automatic do_read(logic [6:0] a, int rst_bit);
    logic [7:0]  b;
    logic [15:0] got;
    b   = {1'b1, a};
    got = '0;
    start_cond();
    expect_ev(1, a, 16'd0);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; half();
    m_scl = 1'b1; half();
    chk("oe_in_turn", 32'(sdata_oe), 0);
    m_scl = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      half();
      if (i == rst_bit) begin
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        chk("oe_after_rst", 32'(sdata_oe), 0);
        chk("busy_after_rst", 32'(busy), 0);
        m_sda = 1'b1;
        m_scl = 1'b1;
        half();
        return;
      end
      got[i] = sda_bus;
      m_scl = 1'b1; half();
      m_scl = 1'b0;
    end
    half();
    chk("oe_released", 32'(sdata_oe), 0);
    chk("read_data", 32'(got), 32'(ref_mem[a]));
    stop_cond();
  endtask

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reg_we || reg_re)
        chk("we_re_exclusive", 32'(reg_we & reg_re), 0);
      if (reg_we) begin
        if (evq.size() == 0) chk("we_expected", 32'(evq.size()), 1);
        else begin
          e = evq.pop_front();
          chk("we_kind", 0, e.kind);
          chk("we_addr", 32'(reg_addr), 32'(e.a));
          chk("we_data", 32'(reg_wdata), 32'(e.d));
        end
      end
      if (reg_re) begin
        if (evq.size() == 0) chk("re_expected", 32'(evq.size()), 1);
        else begin
          e = evq.pop_front();
          chk("re_kind", 1, e.kind);
          chk("re_addr", 32'(reg_addr), 32'(e.a));
        end
      end
      if (frame_err) begin
        if (evq.size() == 0) chk("err_expected", 32'(evq.size()), 1);
        else begin
          e = evq.pop_front();
          chk("err_kind", 2, e.kind);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  a;
    logic [15:0] d;
    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    reg_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 16'($urandom);
      env_mem[i] = ref_mem[i];
    end
    ref_mem[7'h22] = 16'h1234;
    env_mem[7'h22] = 16'h1234;
    cyc(4);
    chk("rst_flags",
        32'({sdata_out, sdata_oe, reg_we, reg_re, frame_err, busy}),
        32'h20);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);
    rst = 1'b0;
    cyc(4);

    do_write(7'h15, 16'hA55A, -1);
    do_read(7'h22, -1);
    do_write(7'h15, 16'h0F0F, 9);
    do_write(7'h7F, 16'hFFFF, -1);
    do_read(7'h7F, -1);
    do_read(7'h15, 7);
    do_read(7'h01, -1);

    // repeated start after four address bits
    start_cond();
    expect_ev(2, 7'd0, 16'd0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    do_write(7'h2C, 16'hBEEF, -1);
    do_read(7'h2C, -1);

    // sclk held low after three address bits
    start_cond();
    for (int i = 0; i < 3; i++) send_bit(1'b0);
`ifdef U8DBG_TGT_TIMEOUT_EN
    expect_ev(2, 7'd0, 16'd0);
    cyc(300);
    chk("busy_after_timeout", 32'(busy), 0);
`else
    cyc(300);
    chk("busy_while_held", 32'(busy), 1);
    expect_ev(2, 7'd0, 16'd0);
`endif
    do_write(7'h40, 16'h8001, -1);

    for (int n = 0; n < 30; n++) begin
      H = $urandom_range(6, 10);
      a = 7'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_read(a, -1);
      else do_write(a, d, -1);
    end

    cyc(20);
    chk("events_drained", 32'(evq.size()), 0);
    chk("final_busy", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
